mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 bit multiplexer between eight requesters.
- Picks one requester and drives the mux select and a one-hot grant.
- Qualifies each beat with a valid/ready handshake toward the downstream consumer.
- Enforces fairness with a rotating priority pointer and a per-grant beat limit.

Parameters:
- N, 8, number of requesters / mux inputs; fixed at 8 for this block.
- SEL_W, 3, select width, log2(N).
- MAX_HOLD, 4, maximum beats transferred per grant before forced release; legal range 1..15.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  per-requester request, level; held high while the requester has beats to send.
- out_ready  input  1  downstream accepts the current beat.
- grant  output  N  one-hot grant, registered; all zero when no grant is active.
- sel  output  SEL_W  mux select, registered; equals the index of the grant bit.
- out_valid  output  1  combinational; equals (state==GRANT) & req[sel].
- busy  output  1  registered; high while in GRANT.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=0, sel=0, busy=0, out_valid=0.
  - Priority pointer ptr=0, beat counter cnt=0.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Else pick the first set req bit scanning ptr, ptr+1, …, ptr+7, mod 8, with wrap-around from 7 to 0.
  - Next edge: grant=onehot(pick), sel=pick, busy=1, cnt=0, state=GRANT.
  - Latency: req rising in cycle t gives grant visible in cycle t+1.
- GRANT:
  - A beat transfers on an edge where out_valid & out_ready are both high; cnt increments on each transfer.
  - Release when either of these holds:
    - (a) req[sel]==0, where the requester withdrew, including before any beat; or
    - (b) a transfer occurs with cnt==MAX_HOLD-1.
  - On release, at the next edge: grant=0, busy=0, ptr=(sel+1) mod 8, cnt=0, state=IDLE.
  - sel keeps its last value in IDLE; consumers must gate with out_valid.
- One bubble cycle in IDLE always separates consecutive grants, even back-to-back to different requesters. Sustained throughput is therefore MAX_HOLD beats per MAX_HOLD+1 cycles at best.
- Simultaneous events:
  - req[sel] falls in the same cycle out_ready is high: out_valid=0, so no transfer; release per (a).
  - Requests from other requesters during GRANT do not preempt. They are considered only in IDLE.
  - The granted requester re-requesting after release gets the lowest priority, since ptr has moved past it.
- out_ready low holds the grant indefinitely. No timeout. cnt counts transfers, not cycles.
- Reset mid-grant: grant, busy and out_valid drop immediately (asynchronous). No partial-beat bookkeeping is kept.
- Invariants:
  - grant is zero or one-hot.
  - grant[sel]==busy.
  - cnt<MAX_HOLD.
  - ptr changes only on release.

Decomposition:
- Package mux8_arb_pkg: N, SEL_W, the state enum {IDLE, GRANT}, and the CNT_W constant (4 bits).
- Sub-module rr_priority_pick: combinational.
  - Inputs: req[N-1:0], ptr[SEL_W-1:0].
  - Outputs: any, pick[SEL_W-1:0].
  - Implementation: rotate, then priority encode, then add ptr back.
- The top level holds the FSM, pointer, counter and registered outputs.

Test Plan:
- Reset with req=8'hFF, then release rst_n → first grant=8'h01, sel=0; after 4 transfers (out_ready=1) grant returns to 0 for 1 cycle, then grant=8'h02, sel=1.
- req=8'h80 only, ptr=0 → grant=8'h80, sel=7. After release, ptr wraps to 0. Next req=8'h81 → grant=8'h01.
- Granted requester 3 drops req after 2 beats → out_valid=0 that cycle, no third transfer, release, ptr=4. req=8'h18 → grant=8'h10.
- out_ready=0 for 10 cycles during grant to requester 5 → grant and sel stable, cnt=0, out_valid=1 throughout. Then out_ready=1 → exactly 4 beats, then release.
- Assert rst_n=0 mid-grant, asynchronously between clock edges → grant=0, busy=0, out_valid=0 before the next edge. After release, arbitration restarts from ptr=0.
- Randomized req/out_ready for 10k cycles, with grant counts per requester compared under constant req=8'hFF → counts differ by at most 1; one-hot and grant[sel]==busy assertions never fire.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// Shared constants and types for the 8-way round-robin mux arbiter.
//   N      : number of requesters / mux inputs
//   SEL_W  : mux select width
//   CNT_W  : beat counter width (covers MAX_HOLD up to 15)
//   state_t: arbiter FSM states
package mux8_arb_pkg;
  localparam int N     = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: finds the first set request bit scanning
// ptr, ptr+1, ... ptr+N-1 (mod N).
//   req  : per-requester request vector
//   ptr  : highest-priority index this round
//   any  : at least one request is set
//   pick : index of the winning requester (only meaningful when any=1)
module rr_priority_pick
  import mux8_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] pick
);
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  // Doubling the vector turns the rotate into a plain slice:
  // rot[i] = req[(ptr+i) mod N].
  assign dbl = {req, req};
  assign rot = dbl[ptr +: N];

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign any  = |req;
  // Undo the rotation; SEL_W-bit add wraps mod N.
  assign pick = off + ptr;
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit mux among eight requesters.
// A grant lasts until the requester drops req or MAX_HOLD beats have
// transferred; one IDLE cycle always separates consecutive grants.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   req       : per-requester level request
//   out_ready : downstream accepts the current beat
//   grant     : registered one-hot grant (zero when idle)
//   sel       : registered mux select (holds last value in IDLE)
//   out_valid : combinational beat qualifier
//   busy      : registered, high while a grant is active
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             busy
);
  state_t           state, state_n;
  logic [N-1:0]     grant_n;
  logic [SEL_W-1:0] sel_n, ptr, ptr_n, pick;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, any, xfer;

  rr_priority_pick u_pick (
    .req  (req),
    .ptr  (ptr),
    .any  (any),
    .pick (pick)
  );

  assign out_valid = (state == GRANT) & req[sel];
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n   = sel;
    busy_n  = busy;
    ptr_n   = ptr;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n       = GRANT;
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          sel_n         = pick;
          busy_n        = 1'b1;
          cnt_n         = '0;
        end
      end
      GRANT: begin
        // Withdrawal wins over anything else: out_valid is already low,
        // so no beat can transfer in that cycle.
        if (!req[sel] || (xfer && cnt == CNT_W'(MAX_HOLD - 1))) begin
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
          ptr_n   = sel + SEL_W'(1);
          cnt_n   = '0;
        end else if (xfer) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel   <= sel_n;
      busy  <= busy_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: a transaction-level model
// predicts grant/sel/busy/out_valid every cycle, and directed scenarios
// pin the model with hand-computed literal expectations.
module tb_mux8_rr_arbiter;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       out_ready;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Who holds the bus, whose turn is first next, how many beats moved.
  bit m_busy;
  int m_who, m_ptr, m_beats, m_sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_who = 0; m_ptr = 0; m_beats = 0; m_sel = 0;
    end else if (!m_busy) begin
      for (int j = 0; j < 8; j++) begin
        if (req[(m_ptr + j) % 8]) begin
          m_busy = 1; m_who = (m_ptr + j) % 8; m_sel = m_who; m_beats = 0;
          break;
        end
      end
    end else begin
      bit done;
      done = 0;
      if (!req[m_who]) done = 1;
      else if (out_ready) begin
        m_beats = m_beats + 1;
        if (m_beats == MAX_HOLD) done = 1;
      end
      if (done) begin
        m_busy = 0; m_ptr = (m_who + 1) % 8; m_beats = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [7:0] eg;
    eg = m_busy ? (8'd1 << m_who) : 8'd0;
    chk("grant", grant, eg);
    chk("sel", sel, m_sel);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_busy && req[m_who]);
    chk("onehot0", $onehot0(grant), 1);
    chk("grant_sel_busy", grant[sel], busy);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  int gcnt [8];
  logic [7:0] prev_g;

  initial begin
    rst_n = 1'b0; req = 8'hFF; out_ready = 1'b1;
    #2;
    chk("rst_grant", grant, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sel", sel, 0);

    // 1: all request; four beats to 0, bubble, then 1
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("t1_grant0", grant, 8'h01);
    chk("t1_sel0", sel, 0);
    step(4);
    chk("t1_bubble", grant, 8'h00);
    step(1);
    chk("t1_grant1", grant, 8'h02);
    chk("t1_sel1", sel, 1);

    // 2: lone requester 7, pointer wraps to 0
    do_reset();
    req = 8'h80;
    step(1);
    chk("t2_grant7", grant, 8'h80);
    chk("t2_sel7", sel, 7);
    step(4);
    chk("t2_release", grant, 8'h00);
    req = 8'h81;
    step(1);
    chk("t2_wrap", grant, 8'h01);
    req = 8'h00;
    step(2);

    // 3: requester 3 withdraws after two beats
    do_reset();
    req = 8'h08;
    step(1);
    chk("t3_grant3", grant, 8'h08);
    step(2);
    req = 8'h00;
    #1;
    chk("t3_valid_drop", out_valid, 0);
    step(1);
    chk("t3_release", grant, 8'h00);
    req = 8'h18;
    step(1);
    chk("t3_ptr4", grant, 8'h10);
    req = 8'h00;
    step(2);

    // 4: requester 5 stalled by out_ready=0, then exactly four beats
    req = 8'h20; out_ready = 1'b0;
    step(1);
    chk("t4_grant5", grant, 8'h20);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t4_hold_grant", grant, 8'h20);
      chk("t4_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    step(3);
    chk("t4_still", grant, 8'h20);
    step(1);
    chk("t4_release", grant, 8'h00);
    req = 8'h00;
    step(1);

    // 5: asynchronous reset between edges, then restart from ptr 0
    req = 8'h41; out_ready = 1'b0;
    step(1);
    chk("t5_grant6", grant, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_grant", grant, 8'h00);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_valid", out_valid, 0);
    step(1);
    rst_n = 1'b1;
    req = 8'hFF;
    step(1);
    chk("t5_restart", grant, 8'h01);

    // 6: random traffic checked by the model every cycle
    for (int i = 0; i < 10000; i++) begin
      req = 8'($urandom);
      out_ready = 1'($urandom);
      step(1);
    end

    // 7: fairness under constant full request
    req = 8'hFF;
    step(1);
    prev_g = grant;
    foreach (gcnt[k]) gcnt[k] = 0;
    for (int i = 0; i < 1500; i++) begin
      out_ready = 1'($urandom);
      step(1);
      if (grant != 0 && prev_g == 0) gcnt[sel]++;
      prev_g = grant;
    end
    begin
      int mn, mx;
      mn = gcnt[0]; mx = gcnt[0];
      foreach (gcnt[k]) begin
        if (gcnt[k] < mn) mn = gcnt[k];
        if (gcnt[k] > mx) mx = gcnt[k];
      end
      chk("fair_spread_le1", (mx - mn) <= 1, 1);
      chk("fair_nonzero", mn > 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
